imem_responder: RTL and testbench

- Instruction-memory slave that answers fetch requests from the core's fetch/decode path.
- Holds a word-addressed array of 32-bit words, each packing two 16-bit instructions (low half at byte offset 0, high half at byte offset 2).
- Returns the full word with a one-cycle ack after a fixed read latency.
- Includes a program-load write port used by the bench/boot loader to fill the array.

---
 rtl/imem_responder.sv | 137 +++++++++++++
 tb/tb_imem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory slave: word array of packed 16-bit instruction pairs plus a program-load write port.
// Latency: ack exactly RD_LATENCY cycles after accept; back-to-back accept in RESP gives one fetch per RD_LATENCY.
// Backpressure: ready drops during WAIT and requests are ignored, not queued. Optional fetch counter: IMEM_FETCH_COUNT_EN.

package simple_processor_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;
endpackage

module imem_responder
   import simple_processor_pkg::*;
#(
   parameter int  MEM_DEPTH  = 256,
   parameter int  RD_LATENCY = 1,
   localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic                  imem_req_i,
   input  logic [ADDR_WIDTH-1:0] imem_addr_i,
   output logic                  imem_ready_o,
   output logic [DATA_WIDTH-1:0] imem_rdata_o,
   output logic                  imem_ack_o,
   output logic                  imem_err_o,
   input  logic                  prog_we_i,
   input  logic [IDX_W-1:0]      prog_addr_i,
   input  logic [DATA_WIDTH-1:0] prog_wdata_i
`ifdef IMEM_FETCH_COUNT_EN
   ,
   output logic [31:0]           fetch_cnt_o
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(MEM_DEPTH);
   localparam logic [3:0]            CNT_LOAD  = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic                  accept;
   logic                  req_err;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic [DATA_WIDTH-1:0] hold_dat;
   logic                  hold_err;

   assign word_idx = imem_addr_i[ADDR_WIDTH-1:2];
   assign req_err  = (imem_addr_i[1:0] != 2'b00) || (word_idx >= DEPTH_LIM);
   assign accept   = imem_req_i && (state != WAIT);

   // Program writes land at the edge; a same-edge read sees the old word.
   always_ff @(posedge clk_i) begin
      if (prog_we_i) begin
         mem[prog_addr_i] <= prog_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         hold_dat <= '0;
         hold_err <= 1'b0;
      end else if (accept) begin
         hold_err <= req_err;
         hold_dat <= req_err ? '0 : mem[word_idx[IDX_W-1:0]];
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cnt <= 4'd0;
      end else if (accept) begin
         cnt <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   always_comb begin
      state_nxt    = state;
      imem_ready_o = 1'b1;
      imem_ack_o   = 1'b0;
      imem_err_o   = 1'b0;
      imem_rdata_o = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (RD_LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            imem_ready_o = 1'b0;
            if (cnt == 4'd0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            imem_ack_o   = 1'b1;
            imem_err_o   = hold_err;
            imem_rdata_o = hold_dat;
            if (accept) begin
               state_nxt = (RD_LATENCY == 1) ? RESP : WAIT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef IMEM_FETCH_COUNT_EN
   // Counts successful fetches only; wraps naturally at 2^32.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         fetch_cnt_o <= 32'd0;
      end else if (imem_ack_o && !imem_err_o) begin
         fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance at RD_LATENCY=1 and one at RD_LATENCY=3.
// Each scenario task drives its own stimulus and checks inline.

module tb_imem_responder;

   logic        clk = 1'b0;
   logic        arst_n;

   logic        req1, pwe1, rdy1, ack1, err1;
   logic [31:0] addr1, pwd1, rd1;
   logic [7:0]  paddr1;
   logic        req3, pwe3, rdy3, ack3, err3;
   logic [31:0] addr3, pwd3, rd3;
   logic [7:0]  paddr3;
`ifdef IMEM_FETCH_COUNT_EN
   logic [31:0] cnt1, cnt3;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imem_responder #(.MEM_DEPTH(256), .RD_LATENCY(1)) u_l1 (
      .clk_i        (clk),
      .arst_ni      (arst_n),
      .imem_req_i   (req1),
      .imem_addr_i  (addr1),
      .imem_ready_o (rdy1),
      .imem_rdata_o (rd1),
      .imem_ack_o   (ack1),
      .imem_err_o   (err1),
      .prog_we_i    (pwe1),
      .prog_addr_i  (paddr1),
      .prog_wdata_i (pwd1)
`ifdef IMEM_FETCH_COUNT_EN
      ,
      .fetch_cnt_o  (cnt1)
`endif
   );

   imem_responder #(.MEM_DEPTH(256), .RD_LATENCY(3)) u_l3 (
      .clk_i        (clk),
      .arst_ni      (arst_n),
      .imem_req_i   (req3),
      .imem_addr_i  (addr3),
      .imem_ready_o (rdy3),
      .imem_rdata_o (rd3),
      .imem_ack_o   (ack3),
      .imem_err_o   (err3),
      .prog_we_i    (pwe3),
      .prog_addr_i  (paddr3),
      .prog_wdata_i (pwd3)
`ifdef IMEM_FETCH_COUNT_EN
      ,
      .fetch_cnt_o  (cnt3)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      req1 = 0; addr1 = 0; pwe1 = 0; paddr1 = 0; pwd1 = 0;
      req3 = 0; addr3 = 0; pwe3 = 0; paddr3 = 0; pwd3 = 0;
      tick();
      tick();
      checks++;
      if (rdy1 !== 1'b1 || ack1 !== 1'b0 || err1 !== 1'b0 || rd1 !== 32'h0) begin
         failures++;
         $display("FAIL reset_l1: rdy=%b ack=%b err=%b rdata=%h, need 1 0 0 0", rdy1, ack1, err1, rd1);
      end
      checks++;
      if (rdy3 !== 1'b1 || ack3 !== 1'b0 || err3 !== 1'b0 || rd3 !== 32'h0) begin
         failures++;
         $display("FAIL reset_l3: rdy=%b ack=%b err=%b rdata=%h, need 1 0 0 0", rdy3, ack3, err3, rd3);
      end
      arst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      pwe1 = 1; paddr1 = 8'd3; pwd1 = 32'hABCD_1234;
      tick();
      pwe1 = 0; req1 = 1; addr1 = 32'h0000_000C;
      tick();
      req1 = 0;
      checks++;
      if (ack1 !== 1'b1 || rd1 !== 32'hABCD_1234 || err1 !== 1'b0) begin
         failures++;
         $display("FAIL single_ack: ack=%b rdata=%h err=%b, need 1 abcd1234 0", ack1, rd1, err1);
      end
      tick();
      checks++;
      if (ack1 !== 1'b0 || rd1 !== 32'h0) begin
         failures++;
         $display("FAIL single_idle: ack=%b rdata=%h, need 0 00000000", ack1, rd1);
      end
   endtask

   task automatic test_latency();
      pwe3 = 1; paddr3 = 8'd0; pwd3 = 32'h1111_2222;
      tick();
      pwe3 = 0; req3 = 1; addr3 = 32'h0;
      tick();
      // Req pulse in the first WAIT cycle must be ignored.
      checks++;
      if (rdy3 !== 1'b0 || ack3 !== 1'b0) begin
         failures++;
         $display("FAIL lat_wait1: rdy=%b ack=%b, need 0 0", rdy3, ack3);
      end
      tick();
      req3 = 0;
      checks++;
      if (rdy3 !== 1'b0 || ack3 !== 1'b0) begin
         failures++;
         $display("FAIL lat_wait2: rdy=%b ack=%b, need 0 0", rdy3, ack3);
      end
      tick();
      checks++;
      if (ack3 !== 1'b1 || rd3 !== 32'h1111_2222 || err3 !== 1'b0 || rdy3 !== 1'b1) begin
         failures++;
         $display("FAIL lat_ack: ack=%b rdata=%h err=%b rdy=%b, need 1 11112222 0 1", ack3, rd3, err3, rdy3);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (ack3 !== 1'b0 || rdy3 !== 1'b1) begin
            failures++;
            $display("FAIL lat_no_extra[%0d]: ack=%b rdy=%b, need 0 1", i, ack3, rdy3);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [3];
      exp[0] = 32'h0000_A000; exp[1] = 32'h0000_B001; exp[2] = 32'h0000_C002;
      for (int i = 0; i < 3; i++) begin
         pwe1 = 1; paddr1 = 8'(i); pwd1 = exp[i];
         tick();
      end
      pwe1 = 0;
      req1 = 1;
      for (int i = 0; i < 3; i++) begin
         addr1 = 32'(i * 4);
         tick();
         checks++;
         if (ack1 !== 1'b1 || rd1 !== exp[i] || err1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b[%0d]: ack=%b rdata=%h err=%b, need 1 %h 0", i, ack1, rd1, err1, exp[i]);
         end
      end
      req1 = 0;
      tick();
      checks++;
      if (ack1 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end: ack=%b, need 0", ack1);
      end
   endtask

   task automatic test_errors();
      req1 = 1; addr1 = 32'h0000_0002;
      tick();
      checks++;
      if (ack1 !== 1'b1 || err1 !== 1'b1 || rd1 !== 32'h0) begin
         failures++;
         $display("FAIL err_misalign: ack=%b err=%b rdata=%h, need 1 1 00000000", ack1, err1, rd1);
      end
      addr1 = 32'h0000_0400;
      tick();
      checks++;
      if (ack1 !== 1'b1 || err1 !== 1'b1 || rd1 !== 32'h0) begin
         failures++;
         $display("FAIL err_range: ack=%b err=%b rdata=%h, need 1 1 00000000", ack1, err1, rd1);
      end
      addr1 = 32'h0000_000C;
      tick();
      checks++;
      if (ack1 !== 1'b1 || err1 !== 1'b0 || rd1 !== 32'hABCD_1234) begin
         failures++;
         $display("FAIL err_recover: ack=%b err=%b rdata=%h, need 1 0 abcd1234", ack1, err1, rd1);
      end
      req1 = 0;
      tick();
      checks++;
      if (ack1 !== 1'b0 || err1 !== 1'b0) begin
         failures++;
         $display("FAIL err_idle: ack=%b err=%b, need 0 0", ack1, err1);
      end
   endtask

   task automatic test_collision();
      pwe1 = 1; paddr1 = 8'd5; pwd1 = 32'h0;
      tick();
      pwd1 = 32'h5555_5555; req1 = 1; addr1 = 32'h0000_0014;
      tick();
      pwe1 = 0;
      checks++;
      if (ack1 !== 1'b1 || rd1 !== 32'h0) begin
         failures++;
         $display("FAIL coll_old: ack=%b rdata=%h, need 1 00000000", ack1, rd1);
      end
      tick();
      req1 = 0;
      checks++;
      if (ack1 !== 1'b1 || rd1 !== 32'h5555_5555) begin
         failures++;
         $display("FAIL coll_new: ack=%b rdata=%h, need 1 55555555", ack1, rd1);
      end
      tick();
   endtask

   task automatic test_wait_write();
      pwe3 = 1; paddr3 = 8'd7; pwd3 = 32'hCAFE_0007;
      tick();
      pwe3 = 0; req3 = 1; addr3 = 32'h0000_001C;
      tick();
      req3 = 0; pwe3 = 1; pwd3 = 32'hDEAD_BEEF;
      tick();
      pwe3 = 0;
      tick();
      checks++;
      if (ack3 !== 1'b1 || rd3 !== 32'hCAFE_0007) begin
         failures++;
         $display("FAIL wait_write: ack=%b rdata=%h, need 1 cafe0007", ack3, rd3);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      req3 = 1; addr3 = 32'h0;
      tick();
      req3 = 0;
      checks++;
      if (rdy3 !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_wait: rdy=%b, need 0", rdy3);
      end
      arst_n = 1'b0;
      #1;
      checks++;
      if (rdy3 !== 1'b1 || ack3 !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_async: rdy=%b ack=%b, need 1 0", rdy3, ack3);
      end
      tick();
      arst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (ack3 !== 1'b0 || rdy3 !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_noack[%0d]: ack=%b rdy=%b, need 0 1", i, ack3, rdy3);
         end
      end
   endtask

`ifdef IMEM_FETCH_COUNT_EN
   task automatic test_fetch_count();
      logic [31:0] addrs [5];
      addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC; addrs[4] = 32'h2;
      checks++;
      if (cnt1 !== 32'd0) begin
         failures++;
         $display("FAIL fcnt_reset: cnt=%0d, need 0", cnt1);
      end
      req1 = 1;
      for (int i = 0; i < 5; i++) begin
         addr1 = addrs[i];
         tick();
      end
      req1 = 0;
      tick();
      tick();
      checks++;
      if (cnt1 !== 32'd4) begin
         failures++;
         $display("FAIL fcnt_total: cnt=%0d, need 4", cnt1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_fetch();
      test_latency();
      test_back_to_back();
      test_errors();
      test_collision();
      test_wait_write();
      test_reset_mid();
`ifdef IMEM_FETCH_COUNT_EN
      test_fetch_count();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
